reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised 2-read/1-write register file for the single-cycle and pipelined datapaths.
//  Adds byte-enable writes, an optional hardwired zero register and same-cycle write-to-read bypass.
//  Integrates a per-register pending scoreboard so decode can stall on unresolved producers.
//  Sits between decode (read/issue) and writeback (write/clear).
// PARAMETERS
//  DATA_W    32  register width in bits; must be a multiple of 8
//  ADDR_W    5   address width; depth = 2**ADDR_W registers
//  ZERO_REG  1   1: register 0 always reads 0, ignores writes, is never pending
//  BYPASS    1   1: a same-cycle write is visible on read ports and clears pend flags combinationally
// PORTS
//  clk        in   1          clock; all state updates on rising edge
//  reset      in   1          synchronous, active-high
//  RegWrite   in   1          write strobe (writeback)
//  writeReg   in   ADDR_W     write address
//  writeData  in   DATA_W     write data
//  byteEn     in   DATA_W/8   per-byte write enable; bit i covers writeData[8i+7:8i]
//  readReg1   in   ADDR_W     read address, port 1
//  readReg2   in   ADDR_W     read address, port 2
//  readData1  out  DATA_W     read data, port 1 (combinational)
//  readData2  out  DATA_W     read data, port 2 (combinational)
//  issueValid in   1          mark issueReg as pending (a producer was issued)
//  issueReg   in   ADDR_W     destination of the issued producer
//  pend1      out  1          readReg1 has an outstanding producer
//  pend2      out  1          readReg2 has an outstanding producer
//  stall      out  1          pend1 | pend2
//  pendCount  out  ADDR_W+1   number of registers currently pending
// BEHAVIOUR
//  Reset: at a rising edge with reset=1, every register <= 0, every pending bit <= 0, pendCount <= 0.
//   Reset beats RegWrite and issueValid in the same cycle. Reset mid-sequence discards all pending state.
//  Write: at a rising edge with RegWrite=1, update each byte of regs[writeReg] whose byteEn bit is 1.
//   Bytes with byteEn=0 keep their value. byteEn=0 writes nothing but still clears pending.
//   With ZERO_REG=1, writes to address 0 are ignored.
//  Read: readDataN = regs[readRegN], zero-latency.
//   With BYPASS=1, RegWrite=1 and writeReg==readRegN: readDataN = writeData bytes where byteEn=1,
//   stored bytes elsewhere.
//   With ZERO_REG=1 and readRegN==0: readDataN = 0, regardless of bypass.
//  Scoreboard, per register r, updated at the rising edge:
//   - set pending[r] if issueValid & issueReg==r
//   - clear pending[r] if RegWrite & writeReg==r
//   - set and clear in the same cycle for the same r: set wins (new producer supersedes).
//   - issue to an already-pending r: stays pending, pendCount unchanged.
//   - ZERO_REG=1: issue to r=0 is ignored.
//  pendCount: tracks the pending-bit population exactly; +1, -1 or 0 per cycle. Never wraps: max 2**ADDR_W.
//  pendN = pending[readRegN]. With BYPASS=1 it is forced to 0 when RegWrite & writeReg==readRegN.
//   This bypass does not apply when the same-cycle issue set-wins rule re-sets that register.
//  Latency: writes visible next cycle (same cycle with BYPASS); pending visible the cycle after issue.
// TESTING
//  T1 reset: write 0xDEADBEEF to r5, then reset=1 for one edge -> readData1(r5)=0, pendCount=0, stall=0.
//  T2 bytes: r3=0x11223344; write 0xAABBCCDD with byteEn=4'b0101 -> r3 reads 0x11BB33DD.
//  T3 bypass: RegWrite to r7 with 0x5A5A5A5A, readReg2=7 same cycle ->
//     readData2=0x5A5A5A5A before the edge (BYPASS=1); old value when BYPASS=0.
//  T4 zero: write 0xFFFFFFFF to r0, issueValid to r0 -> r0 reads 0, pend1=0, pendCount=0.
//  T5 scoreboard: issue r4 -> next cycle pend1(r4)=1, stall=1, pendCount=1.
//     RegWrite r4 -> pend1=0 the same cycle; pendCount=0 after the edge.
//  T6 collision: r9 pending; in one cycle issue r9 and write r9 ->
//     r9 still pending, pendCount unchanged. Then reset -> all pending cleared.

Source files
------------

// File: rtl/reg_file_sb.sv
// 2R/1W register file with byte-enable writes, optional zero register, write-to-read bypass and a pending scoreboard.
// Reads and pend flags are combinational; writes and scoreboard updates take effect at the next clock edge; no backpressure, stall is advisory to decode.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWrite,
    input  logic [ADDR_W-1:0]   writeReg,
    input  logic [DATA_W-1:0]   writeData,
    input  logic [DATA_W/8-1:0] byteEn,
    input  logic [ADDR_W-1:0]   readReg1,
    input  logic [ADDR_W-1:0]   readReg2,
    output logic [DATA_W-1:0]   readData1,
    output logic [DATA_W-1:0]   readData2,
    input  logic                issueValid,
    input  logic [ADDR_W-1:0]   issueReg,
    output logic                pend1,
    output logic                pend2,
    output logic                stall,
    output logic [ADDR_W:0]     pendCount
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;
    logic [DATA_W-1:0] wr_mask;
    logic              wr_ok;
    logic              iss_ok;
    logic              cnt_inc;
    logic              cnt_dec;
    logic              wr_hit1;
    logic              wr_hit2;
    logic              set_hit1;
    logic              set_hit2;

    assign wr_ok  = RegWrite   && !((ZERO_REG != 0) && (writeReg == '0));
    assign iss_ok = issueValid && !((ZERO_REG != 0) && (issueReg == '0));

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < NB; b++) begin
            wr_mask[8*b +: 8] = {8{byteEn[b]}};
        end
    end

    // Issue is applied after the clear so a same-cycle set wins.
    always_comb begin
        pending_nxt = pending;
        if (RegWrite) begin
            pending_nxt[writeReg] = 1'b0;
        end
        if (iss_ok) begin
            pending_nxt[issueReg] = 1'b1;
        end
    end

    // Population changes by at most one in each direction per cycle.
    assign cnt_inc   = iss_ok && !pending[issueReg];
    assign cnt_dec   = RegWrite && pending[writeReg] && !(iss_ok && (issueReg == writeReg));
    assign count_nxt = count_q + CW'(cnt_inc) - CW'(cnt_dec);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            pending <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                regs[writeReg] <= (regs[writeReg] & ~wr_mask) | (writeData & wr_mask);
            end
            pending <= pending_nxt;
            count_q <= count_nxt;
        end
    end

    function automatic logic [DATA_W-1:0] rd_val(
        input logic [DATA_W-1:0] stored,
        input logic [ADDR_W-1:0] addr,
        input logic              hit,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] mask
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if ((BYPASS != 0) && hit) begin
            v = (stored & ~mask) | (wdata & mask);
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    assign wr_hit1  = RegWrite && (writeReg == readReg1);
    assign wr_hit2  = RegWrite && (writeReg == readReg2);
    assign set_hit1 = iss_ok && (issueReg == readReg1);
    assign set_hit2 = iss_ok && (issueReg == readReg2);

    assign readData1 = rd_val(regs[readReg1], readReg1, wr_hit1, writeData, wr_mask);
    assign readData2 = rd_val(regs[readReg2], readReg2, wr_hit2, writeData, wr_mask);

    // A same-cycle write hides the pend flag unless an issue re-arms that register.
    assign pend1 = pending[readReg1] && !((BYPASS != 0) && wr_hit1 && !set_hit1);
    assign pend2 = pending[readReg2] && !((BYPASS != 0) && wr_hit2 && !set_hit2);
    assign stall = pend1 | pend2;

    assign pendCount = count_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboarded bench for reg_file_sb: two instances (zero-reg+bypass, and neither) driven in lockstep against a behavioural model.
module tb_reg_file_sb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, RegWrite, issueValid;
    logic [4:0]  writeReg, readReg1, readReg2, issueReg;
    logic [31:0] writeData;
    logic [3:0]  byteEn;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_p1, a_p2, a_st, b_p1, b_p2, b_st;
    logic [5:0]  a_cnt, b_cnt;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .writeReg(writeReg),
        .writeData(writeData), .byteEn(byteEn), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(a_rd1), .readData2(a_rd2), .issueValid(issueValid), .issueReg(issueReg),
        .pend1(a_p1), .pend2(a_p2), .stall(a_st), .pendCount(a_cnt));

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .writeReg(writeReg),
        .writeData(writeData), .byteEn(byteEn), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(b_rd1), .readData2(b_rd2), .issueValid(issueValid), .issueReg(issueReg),
        .pend1(b_p1), .pend2(b_p2), .stall(b_st), .pendCount(b_cnt));

    typedef struct {
        int          id;
        int          k;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        p1;
        logic        p2;
        logic        st;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          step_id = 0;
    logic [31:0] m_regs [2][32];
    bit          m_pend [2][32];

    // Instance 0 has a zero register and bypass; instance 1 has neither.
    function automatic bit has_zero(int k); return k == 0; endfunction
    function automatic bit has_byp(int k);  return k == 0; endfunction

    function automatic logic [31:0] m_read(int k, logic [4:0] a);
        logic [31:0] v;
        if (has_zero(k) && a == 0) return 32'h0;
        v = m_regs[k][a];
        if (has_byp(k) && RegWrite && writeReg == a)
            for (int b = 0; b < 4; b++)
                if (byteEn[b]) v[8*b +: 8] = writeData[8*b +: 8];
        return v;
    endfunction

    function automatic logic m_pflag(int k, logic [4:0] a);
        if (has_zero(k) && a == 0) return 1'b0;
        if (has_byp(k) && RegWrite && writeReg == a && !(issueValid && issueReg == a))
            return 1'b0;
        return m_pend[k][a];
    endfunction

    function automatic logic [5:0] m_count(int k);
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_pend[k][r]);
        return 6'(n);
    endfunction

    task automatic m_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int r = 0; r < 32; r++) begin
                    m_regs[k][r] = 32'h0;
                    m_pend[k][r] = 1'b0;
                end
            end else begin
                if (RegWrite && !(has_zero(k) && writeReg == 0))
                    for (int b = 0; b < 4; b++)
                        if (byteEn[b]) m_regs[k][writeReg][8*b +: 8] = writeData[8*b +: 8];
                if (RegWrite) m_pend[k][writeReg] = 1'b0;
                if (issueValid && !(has_zero(k) && issueReg == 0)) m_pend[k][issueReg] = 1'b1;
            end
        end
    endtask

    task automatic step(input bit chk, input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] be, input logic [4:0] r1,
                        input logic [4:0] r2, input logic iv, input logic [4:0] ia);
        exp_t e;
        reset = rst; RegWrite = we; writeReg = wa; writeData = wd; byteEn = be;
        readReg1 = r1; readReg2 = r2; issueValid = iv; issueReg = ia;
        step_id++;
        if (chk) begin
            for (int k = 0; k < 2; k++) begin
                e.id  = step_id;
                e.k   = k;
                e.rd1 = m_read(k, r1);
                e.rd2 = m_read(k, r2);
                e.p1  = m_pflag(k, r1);
                e.p2  = m_pflag(k, r2);
                e.st  = e.p1 | e.p2;
                e.cnt = m_count(k);
                q.push_back(e);
            end
        end
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic cmp(input string name, input exp_t e, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s step %0d inst %0d got %h want %h", name, e.id, e.k, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("readData1", e, e.k == 0 ? a_rd1 : b_rd1, e.rd1);
            cmp("readData2", e, e.k == 0 ? a_rd2 : b_rd2, e.rd2);
            cmp("pend1",     e, 32'(e.k == 0 ? a_p1 : b_p1), 32'(e.p1));
            cmp("pend2",     e, 32'(e.k == 0 ? a_p2 : b_p2), 32'(e.p2));
            cmp("stall",     e, 32'(e.k == 0 ? a_st : b_st), 32'(e.st));
            cmp("pendCount", e, 32'(e.k == 0 ? a_cnt : b_cnt), 32'(e.cnt));
        end
    end

    initial begin
        reset = 1'b1; RegWrite = 1'b0; writeReg = '0; writeData = '0; byteEn = '0;
        readReg1 = '0; readReg2 = '0; issueValid = 1'b0; issueReg = '0;
        @(posedge clk);
        #1;
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset state and reset clearing written data
        step(1, 0, 0, 0, 0, 0, 5, 9, 0, 0);
        step(1, 0, 1, 5, 32'hDEADBEEF, 4'hF, 5, 5, 0, 0);
        step(1, 0, 0, 0, 0, 0, 5, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 5, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 5, 0, 0, 0);
        // partial byte writes, including an empty mask
        step(1, 0, 1, 3, 32'h11223344, 4'hF, 3, 3, 0, 0);
        step(1, 0, 1, 3, 32'hAABBCCDD, 4'b0101, 3, 3, 0, 0);
        step(1, 0, 1, 3, 32'hFFFFFFFF, 4'b0000, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 3, 3, 0, 0);
        // bypass on port 2
        step(1, 0, 1, 7, 32'h5A5A5A5A, 4'hF, 0, 7, 0, 0);
        step(1, 0, 0, 0, 0, 0, 7, 7, 0, 0);
        // zero register
        step(1, 0, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // scoreboard issue / resolve
        step(1, 0, 0, 0, 0, 0, 4, 0, 1, 4);
        step(1, 0, 0, 0, 0, 0, 4, 4, 0, 0);
        step(1, 0, 1, 4, 32'h00000044, 4'hF, 4, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 4, 0, 0, 0);
        // set-wins collision, re-issue to pending, then reset
        step(1, 0, 0, 0, 0, 0, 9, 0, 1, 9);
        step(1, 0, 0, 0, 0, 0, 9, 0, 1, 9);
        step(1, 0, 1, 9, 32'h99999999, 4'hF, 9, 9, 1, 9);
        step(1, 0, 0, 0, 0, 0, 9, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 9, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 9, 0, 0, 0);
        // fill every register's pending bit, then drain with simultaneous issue+write
        for (int r = 0; r < 32; r++) step(1, 0, 0, 0, 0, 0, 5'(r), 0, 1, 5'(r));
        step(1, 0, 0, 0, 0, 0, 31, 1, 0, 0);
        for (int r = 0; r < 32; r++) step(1, 0, 1, 5'(r), 32'(r), 4'hF, 5'(r), 5'((r + 1) % 32), 1, 5'((r + 2) % 32));
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            step(1, ($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), wa, $urandom,
                 4'($urandom), ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
                 ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
                 ($urandom_range(0, 4) < 2), ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain %0d expected entries never checked", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
